// File: rtl/weight_bram_responder.sv
// rtl/weight_bram_responder.sv - dual-port weight memory with read-first port A, RMW port B and LFSR fill
module weight_bram_responder #(
  parameter int          NUM_NEURONS = 256,
  parameter int          INPUT_SIZE  = 784,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = NUM_NEURONS * INPUT_SIZE,
  parameter logic [15:0] INIT_SEED   = 16'hACE1,
  localparam int         AW          = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         addr_a,
  input  logic                  en_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]         addr_b,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic                  init_start,
  output logic                  init_busy,
  output logic                  init_done,
  output logic                  collision,
  output logic                  addr_err
);

  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [15:0]   LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [AW-1:0]           fill_addr;
  logic [15:0]             lfsr;
  logic [15:0]             lfsr_nxt;
  logic [DATA_WIDTH-1:0]   fill_word;
  logic                    fill_we;
  logic                    port_act;
  logic                    a_ok, b_ok;
  logic                    a_rd, b_rd, b_wr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Galois step and the sign-extended 12-bit fill word taken before the step
  assign lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  assign fill_word = {{(DATA_WIDTH-12){lfsr[11]}}, lfsr[11:0]};

  // User ports are only live outside the fill; out-of-range addresses never touch memory
  assign port_act = (state == S_IDLE);
  assign a_ok     = ({1'b0, addr_a} < DEPTH_W);
  assign b_ok     = ({1'b0, addr_b} < DEPTH_W);
  assign a_rd     = port_act && en_a;
  assign b_rd     = port_act && en_b && !we_b;
  assign b_wr     = port_act && en_b && we_b && b_ok;

  // Init FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Init FSM next state and status outputs
  always_comb begin
    state_nxt = state;
    init_busy = 1'b0;
    init_done = 1'b0;
    fill_we   = 1'b0;
    case (state)
      S_IDLE: if (init_start) state_nxt = S_FILL;
      S_FILL: begin
        init_busy = 1'b1;
        fill_we   = 1'b1;
        if (fill_addr == LAST_ADDR) state_nxt = S_DONE;
      end
      S_DONE: begin
        init_busy = 1'b1;
        init_done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fill address counter and LFSR, reloaded whenever a fill is launched
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_addr <= '0;
      lfsr      <= INIT_SEED;
    end else if (port_act && init_start) begin
      fill_addr <= '0;
      lfsr      <= INIT_SEED;
    end else if (fill_we) begin
      fill_addr <= fill_addr + AW'(1);
      lfsr      <= lfsr_nxt;
    end
  end

  // Single write port shared by the fill and port B; reset blocks writes but never clears contents
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_we)   mem[fill_addr] <= fill_word;
      else if (b_wr) mem[addr_b]    <= wdata_b;
    end
  end

  // Read-first data registers and one-cycle event flags
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a   <= '0;
      rdata_b   <= '0;
      collision <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      if (a_rd) rdata_a <= a_ok ? mem[addr_a] : '0;
      if (b_rd) rdata_b <= b_ok ? mem[addr_b] : '0;
      collision <= port_act && en_a && en_b && we_b && a_ok && (addr_a == addr_b);
      addr_err  <= port_act && ((en_a && !a_ok) || (en_b && !b_ok));
    end
  end

endmodule

// File: tb/tb_weight_bram_responder.sv
// tb/tb_weight_bram_responder.sv - randomized and directed check of weight_bram_responder against a behavioural model
module tb_weight_bram_responder;

  localparam int DEPTH = 800;
  localparam int AW    = 10;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic          en_a = 1'b0, en_b = 1'b0, we_b = 1'b0, init_start = 1'b0;
  logic [DW-1:0] wdata_b = '0;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          init_busy, init_done, collision, addr_err;

  weight_bram_responder #(
    .NUM_NEURONS(1), .INPUT_SIZE(DEPTH), .DATA_WIDTH(DW), .INIT_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst),
    .addr_a(addr_a), .en_a(en_a), .rdata_a(rdata_a),
    .addr_b(addr_b), .en_b(en_b), .we_b(we_b), .wdata_b(wdata_b), .rdata_b(rdata_b),
    .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
    .collision(collision), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [31:0] sext12(input logic [15:0] v);
    return {{20{v[11]}}, v[11:0]};
  endfunction

  // Behavioural model: memory array, pending fill words, and the last value read on each port
  logic [31:0] model_mem [DEPTH];
  logic [31:0] m_a = '0, m_b = '0;
  bit          m_coll = 0, m_err = 0;
  int          busy_left = 0;
  int          fill_idx = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  initial for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

  always @(posedge clk) begin
    int  ia, ib;
    bit  a_in, b_in;
    ia = int'(addr_a);
    ib = int'(addr_b);
    a_in = ia < DEPTH;
    b_in = ib < DEPTH;
    if (rst) begin
      m_a = '0; m_b = '0; m_coll = 0; m_err = 0; busy_left = 0;
    end else if (busy_left > 0) begin
      if (fill_idx < DEPTH) begin
        model_mem[fill_idx] = sext12(m_lfsr);
        m_lfsr = lfsr_step(m_lfsr);
        fill_idx++;
      end
      busy_left--;
      m_coll = 0;
      m_err  = 0;
    end else begin
      m_coll = en_a && en_b && we_b && a_in && (ia == ib);
      m_err  = (en_a && !a_in) || (en_b && !b_in);
      if (en_a) m_a = a_in ? model_mem[ia] : 32'h0;
      if (en_b && !we_b) m_b = b_in ? model_mem[ib] : 32'h0;
      if (en_b && we_b && b_in) model_mem[ib] = wdata_b;
      if (init_start) begin
        busy_left = DEPTH + 1;
        fill_idx  = 0;
        m_lfsr    = 16'hACE1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("rdata_a", rdata_a, m_a);
      cmp("rdata_b", rdata_b, m_b);
      cmp("init_busy", {31'b0, init_busy}, {31'b0, busy_left > 0});
      cmp("init_done", {31'b0, init_done}, {31'b0, busy_left == 1});
      cmp("collision", {31'b0, collision}, {31'b0, m_coll});
      cmp("addr_err", {31'b0, addr_err}, {31'b0, m_err});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_in();
    en_a = 0; en_b = 0; we_b = 0; init_start = 0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return AW'($urandom_range(DEPTH, 1023));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic a_read(input int adr);
    idle_in();
    en_a = 1; addr_a = AW'(adr);
    tick();
    idle_in();
  endtask

  task automatic b_write(input int adr, input logic [31:0] d);
    idle_in();
    en_b = 1; we_b = 1; addr_b = AW'(adr); wdata_b = d;
    tick();
    idle_in();
  endtask

  task automatic wait_idle();
    int guard = 0;
    idle_in();
    while (init_busy && guard < 2000) begin guard++; tick(); end
    if (init_busy) cmp("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  logic [31:0] pre [DEPTH];
  logic [31:0] lit [4];

  initial begin
    int cnt, dcnt;
    logic [15:0] l;
    lit[0] = 32'hFFFF_FCE1; lit[1] = 32'h0000_0270;
    lit[2] = 32'h0000_0138; lit[3] = 32'hFFFF_F89C;

    // reset
    repeat (3) tick();
    rst = 0;
    tick();
    chk_en = 1;
    cmp("reset_rdata_a", rdata_a, 32'h0);
    cmp("reset_busy", {31'b0, init_busy}, 32'h0);

    // full fill with junk requests during busy, all of which must be ignored
    init_start = 1;
    tick();
    cnt = 0; dcnt = 0;
    while (init_busy && cnt < 2000) begin
      cnt++;
      if (init_done) dcnt++;
      en_a = 1'($urandom); en_b = 1'($urandom); we_b = 1'($urandom);
      init_start = 1'($urandom);
      addr_a = rand_addr(); addr_b = rand_addr(); wdata_b = $urandom;
      tick();
    end
    idle_in();
    cmp("fill_busy_cycles", cnt, DEPTH + 1);
    cmp("fill_done_pulses", dcnt, 1);
    for (int i = 0; i < 4; i++) begin
      a_read(i);
      cmp("fill_word_lit", rdata_a, lit[i]);
    end

    // B write then A read; rdata_b untouched by the write
    b_write(5, 32'h0001_8000);
    a_read(5);
    cmp("wr_rd_a", rdata_a, 32'h0001_8000);
    cmp("wr_rd_b_unchanged", rdata_b, 32'h0);

    // read-first collision
    b_write(7, 32'h0000_1000);
    en_a = 1; addr_a = 7; en_b = 1; we_b = 1; addr_b = 7; wdata_b = 32'h0000_2000;
    tick();
    idle_in();
    cmp("coll_old_word", rdata_a, 32'h0000_1000);
    cmp("coll_pulse", {31'b0, collision}, 32'h1);
    tick();
    cmp("coll_drop", {31'b0, collision}, 32'h0);
    a_read(7);
    cmp("coll_new_word", rdata_a, 32'h0000_2000);

    // out-of-range accesses
    b_write(DEPTH, 32'hDEAD_BEEF);
    cmp("oor_wr_err", {31'b0, addr_err}, 32'h1);
    tick();
    cmp("oor_err_drop", {31'b0, addr_err}, 32'h0);
    a_read(DEPTH);
    cmp("oor_rd_zero", rdata_a, 32'h0);
    cmp("oor_rd_err", {31'b0, addr_err}, 32'h1);

    // back-to-back read-modify-write over the first 784 words
    for (int k = 0; k < DEPTH; k++) pre[k] = model_mem[k];
    for (int k = 0; k < 784; k++) begin
      en_b = 1; we_b = 0; addr_b = AW'(k);
      tick();
      we_b = 1; wdata_b = rdata_b + 32'h0000_0148;
      tick();
    end
    idle_in();
    for (int k = 0; k < 784; k += 37) begin
      a_read(k);
      cmp("rmw_plus_328", rdata_a, pre[k] + 32'd328);
    end
    a_read(790);
    cmp("rmw_untouched", rdata_a, pre[790]);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      en_a = 1'($urandom); en_b = 1'($urandom); we_b = 1'($urandom);
      addr_a = rand_addr();
      addr_b = ($urandom_range(0, 3) == 0) ? addr_a : rand_addr();
      wdata_b = $urandom;
      init_start = ($urandom_range(0, 999) == 0);
      tick();
    end
    wait_idle();

    // reset in the middle of a fill
    for (int k = 0; k < DEPTH; k++) pre[k] = model_mem[k];
    init_start = 1;
    tick();
    init_start = 0;
    dcnt = 0;
    repeat (8) begin
      if (init_done) dcnt++;
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    cmp("abort_busy", {31'b0, init_busy}, 32'h0);
    cmp("abort_done", {31'b0, init_done}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (init_done) dcnt++;
      tick();
    end
    cmp("abort_no_done", dcnt, 0);
    l = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      a_read(i);
      if (i < 4) cmp("abort_lit", rdata_a, lit[i]);
      if (i < 8) cmp("abort_filled", rdata_a, sext12(l));
      else       cmp("abort_kept", rdata_a, pre[i]);
      l = lfsr_step(l);
    end

    tick();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_bram_responder.md
WEIGHT_BRAM_RESPONDER -- requirements
Module: weight_bram_responder

Interface
REQ-001 Parameter NUM_NEURONS, default 256, neuron count.
REQ-002 Parameter INPUT_SIZE, default 784, weights per neuron.
REQ-003 Parameter DATA_WIDTH, default 32, Q16.16 word width.
REQ-004 Parameter DEPTH, default NUM_NEURONS*INPUT_SIZE, word count; AW = $clog2(DEPTH).
REQ-005 Parameter INIT_SEED, default 16'hACE1, LFSR seed for the fill pattern; must be nonzero.
REQ-006 Port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port addr_a, input, AW, port A (inference) read address.
REQ-009 Port en_a, input, 1, port A read request.
REQ-010 Port rdata_a, output, DATA_WIDTH, port A read data.
REQ-011 Port addr_b, input, AW, port B (plasticity) address.
REQ-012 Port en_b, input, 1, port B request.
REQ-013 Port we_b, input, 1, port B write qualifier; valid only with en_b.
REQ-014 Port wdata_b, input, DATA_WIDTH, port B write data.
REQ-015 Port rdata_b, output, DATA_WIDTH, port B read data.
REQ-016 Port init_start, input, 1, pulse that starts the pseudo-random fill.
REQ-017 Port init_busy, output, 1, high while the fill runs.
REQ-018 Port init_done, output, 1, one-cycle pulse when the fill completes.
REQ-019 Port collision, output, 1, one-cycle pulse on a same-address A-read/B-write.
REQ-020 Port addr_err, output, 1, one-cycle pulse on any enabled access with address >= DEPTH.

Function
REQ-021 Read latency is 1 cycle: en_a (or en_b with !we_b) at edge N -> rdata valid after edge N+1; each rdata holds its value until the next read on that port.
REQ-022 Port B write (en_b && we_b) updates mem[addr_b] at the edge; rdata_b is unchanged by a write.
REQ-023 Same cycle en_a and B write to the same address: rdata_a returns the OLD word (read-first); collision pulses the next cycle; the write completes.
REQ-024 Back-to-back B read then B write at one address (read-modify-write) works every 2 cycles with no stall.
REQ-025 Address >= DEPTH: a read returns 0, a write is dropped, and addr_err pulses the next cycle.
REQ-026 Init FSM states: IDLE -> FILL on init_start; FILL -> DONE after writing address DEPTH-1; DONE -> IDLE after 1 cycle with init_done = 1.
REQ-027 FILL writes one word per cycle at fill_addr 0..DEPTH-1 (DEPTH cycles total), using the 16-bit Galois LFSR with taps mask 16'hB400, loaded with INIT_SEED on entry and stepped once per word.
REQ-028 Fill word = sign-extend of lfsr[11:0] to DATA_WIDTH (range about +/-0.031 in Q16.16), using the LFSR value before the step.
REQ-029 init_busy = 1 in FILL and DONE; while busy, en_a and en_b are ignored, rdata outputs hold, and collision and addr_err stay 0.
REQ-030 init_start while busy is ignored; init_start and en_b in the same IDLE cycle: the B access is served, then FILL begins.
REQ-031 Memory contents are not cleared by rst; only the fill changes them besides port B.

Reset
REQ-032 On rst: FSM = IDLE, fill_addr = 0, LFSR = INIT_SEED, rdata_a = 0, rdata_b = 0, init_busy = 0, init_done = 0, collision = 0, addr_err = 0.
REQ-033 rst during FILL aborts the fill at the next edge; partially written words remain; no init_done pulse.

Verification
REQ-034 Write 32'h0001_8000 to B addr 5, then A read addr 5 -> rdata_a = 32'h0001_8000 one cycle later; rdata_b unchanged.
REQ-035 Preload addr 7 = 32'h0000_1000; same cycle A read 7 and B write 7 = 32'h0000_2000 -> rdata_a = 32'h0000_1000, collision = 1 for one cycle; a later A read returns 32'h0000_2000.
REQ-036 RMW loop: B read addr k, B write addr k = rdata_b + 32'h0000_0148, for k = 0..783 -> every word increases by exactly 328, with no extra cycles.
REQ-037 init_start with DEPTH = 16 -> init_busy high for 17 cycles, init_done pulses once, mem[0] = sign-extend(12'hCE1) = 32'hFFFF_FCE1, and all 16 words match the model LFSR sequence.
REQ-038 B write to address DEPTH with 32'hDEAD_BEEF -> addr_err pulse, no memory change; A read of address DEPTH -> rdata_a = 0.
REQ-039 rst asserted at fill_addr = 8 -> next cycle init_busy = 0, no init_done, words 0..7 filled, words 8..DEPTH-1 unchanged.
